// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream, instruction-memory write and status bundle
// for the program loader.
//   rx_data/rx_valid/rx_ready : host byte stream (valid/ready handshake)
//   reload                    : request a new load from RUN or ERR
//   mem_we/mem_addr/mem_wdata : instruction-memory write port
//   cpu_rst/load_done/load_err: CPU reset and load status
//   words_loaded              : words written during the current load
// Modports: master = host/byte source side, slave = loader side.
interface prog_loader_if #(
    parameter int AW = 4
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          reload;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    modport master (
        output rx_data, rx_valid, reload,
        input  rx_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_rst, load_done, load_err, words_loaded
    );

    modport slave (
        input  rx_data, rx_valid, reload,
        output rx_ready, mem_we, mem_addr, mem_wdata,
        output cpu_rst, load_done, load_err, words_loaded
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: fills the CPU instruction memory from a byte stream
// (header N, 4*N payload bytes MSB first, XOR checksum byte) and then
// releases the CPU from reset. The CPU stays in reset while loading and
// after any failed load until reload is requested.
// Ports:
//   clk     : system clock, rising edge
//   sys_rst : synchronous active-high reset
//   bus     : prog_loader_if slave modport (stream, memory write, status)
//
// state | meaning
// HDR   | waiting for the word-count header byte
// DATA  | assembling payload words, one memory write per 4 bytes
// CHK   | waiting for the checksum byte
// RUN   | load good, CPU released
// ERR   | bad header or checksum, CPU held in reset
module prog_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          sys_rst,
    prog_loader_if.slave  bus
);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t        state, state_n;
    logic [AW:0]   n_words, n_words_n;
    logic [1:0]    byte_idx, byte_idx_n;
    logic [AW-1:0] word_idx, word_idx_n;
    logic [7:0]    xor_acc, xor_acc_n;
    logic [31:0]   asm_word, asm_word_n;

    logic          rx_ready_r, rx_ready_n;
    logic          cpu_rst_r, cpu_rst_n;
    logic          load_done_r, load_done_n;
    logic          load_err_r, load_err_n;
    logic          mem_we_r, mem_we_n;
    logic [AW-1:0] mem_addr_r, mem_addr_n;
    logic [31:0]   mem_wdata_r, mem_wdata_n;
    logic [AW:0]   words_loaded_r, words_loaded_n;

    logic          xfer;
    logic [31:0]   asm_shift;
    logic [AW:0]   words_inc;

    // rx_ready_r always mirrors the registered state, so it is a safe
    // qualifier for the handshake.
    assign xfer      = bus.rx_valid && rx_ready_r;
    assign asm_shift = {asm_word[23:0], bus.rx_data};
    assign words_inc = words_loaded_r + 1'b1;

    always_comb begin
        state_n        = state;
        n_words_n      = n_words;
        byte_idx_n     = byte_idx;
        word_idx_n     = word_idx;
        xor_acc_n      = xor_acc;
        asm_word_n     = asm_word;
        mem_we_n       = 1'b0;
        mem_addr_n     = mem_addr_r;
        mem_wdata_n    = mem_wdata_r;
        words_loaded_n = words_loaded_r;

        case (state)
            ST_HDR: begin
                if (xfer) begin
                    xor_acc_n  = bus.rx_data;
                    n_words_n  = bus.rx_data[AW:0];
                    byte_idx_n = '0;
                    word_idx_n = '0;
                    asm_word_n = '0;
                    if (bus.rx_data != 8'd0 && bus.rx_data <= DEPTH_B)
                        state_n = ST_DATA;
                    else
                        state_n = ST_ERR;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    asm_word_n = asm_shift;
                    xor_acc_n  = xor_acc ^ bus.rx_data;
                    byte_idx_n = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        mem_we_n       = 1'b1;
                        mem_addr_n     = word_idx;
                        mem_wdata_n    = asm_shift;
                        word_idx_n     = word_idx + 1'b1;
                        words_loaded_n = words_inc;
                        if (words_inc == n_words)
                            state_n = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (xfer)
                    state_n = (bus.rx_data == xor_acc) ? ST_RUN : ST_ERR;
            end
            ST_RUN, ST_ERR: begin
                if (bus.reload) begin
                    state_n        = ST_HDR;
                    n_words_n      = '0;
                    byte_idx_n     = '0;
                    word_idx_n     = '0;
                    xor_acc_n      = '0;
                    asm_word_n     = '0;
                    words_loaded_n = '0;
                end
            end
            default: state_n = ST_HDR;
        endcase

        // Status outputs are registered copies of the next state.
        rx_ready_n  = (state_n == ST_HDR) || (state_n == ST_DATA) || (state_n == ST_CHK);
        cpu_rst_n   = (state_n != ST_RUN);
        load_done_n = (state_n == ST_RUN);
        load_err_n  = (state_n == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state          <= ST_HDR;
            n_words        <= '0;
            byte_idx       <= '0;
            word_idx       <= '0;
            xor_acc        <= '0;
            asm_word       <= '0;
            rx_ready_r     <= 1'b1;
            cpu_rst_r      <= 1'b1;
            load_done_r    <= 1'b0;
            load_err_r     <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= '0;
            mem_wdata_r    <= '0;
            words_loaded_r <= '0;
        end else begin
            state          <= state_n;
            n_words        <= n_words_n;
            byte_idx       <= byte_idx_n;
            word_idx       <= word_idx_n;
            xor_acc        <= xor_acc_n;
            asm_word       <= asm_word_n;
            rx_ready_r     <= rx_ready_n;
            cpu_rst_r      <= cpu_rst_n;
            load_done_r    <= load_done_n;
            load_err_r     <= load_err_n;
            mem_we_r       <= mem_we_n;
            mem_addr_r     <= mem_addr_n;
            mem_wdata_r    <= mem_wdata_n;
            words_loaded_r <= words_loaded_n;
        end
    end

    assign bus.rx_ready     = rx_ready_r;
    assign bus.cpu_rst      = cpu_rst_r;
    assign bus.load_done    = load_done_r;
    assign bus.load_err     = load_err_r;
    assign bus.mem_we       = mem_we_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_wdata    = mem_wdata_r;
    assign bus.words_loaded = words_loaded_r;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives byte streams into prog_loader and compares the
// observed memory writes and final status with a stream-level model.
module tb_prog_loader;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.AW(AW)) bus ();
    prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    int  n_checks = 0;
    int  n_errs   = 0;
    bit  mon_en   = 1'b0;
    wr_t obs_wr[$];
    wr_t exp_wr[$];
    bit  exp_done, exp_err;
    int  exp_words;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!sys_rst) begin
            if (bus.mem_we === 1'b1)
                obs_wr.push_back(wr_t'{bus.mem_addr, bus.mem_wdata});
            if (mon_en) begin
                chk("flags_exclusive", bus.load_done & bus.load_err, 0);
                chk("cpu_rst_vs_done", bus.cpu_rst, !bus.load_done);
            end
        end
    end

    function automatic byte_q_t make_stream(int n, word_q_t words, bit bad);
        byte_q_t q;
        logic [7:0] x;
        q.push_back(8'(n));
        x = 8'(n);
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                q.push_back(words[i][8*b +: 8]);
                x ^= words[i][8*b +: 8];
            end
        end
        q.push_back(bad ? (x ^ 8'h01) : x);
        return q;
    endfunction

    // Reference: decode the whole stream by its format rules.
    function automatic void model(byte_q_t q);
        int n;
        logic [7:0] x;
        exp_wr.delete();
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_words = 0;
        n = int'(q[0]);
        if (n < 1 || n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i <= 4 * n; i++) x ^= q[i];
        for (int w = 0; w < n; w++)
            exp_wr.push_back(wr_t'{AW'(w), {q[1+4*w], q[2+4*w], q[3+4*w], q[4+4*w]}});
        exp_words = n;
        if (q[4*n+1] == x) exp_done = 1'b1;
        else               exp_err  = 1'b1;
    endfunction

    // gap: 0 back-to-back, 1 valid toggles every cycle, 2 random idle cycles
    task automatic send(byte_q_t q, int gap);
        foreach (q[i]) begin
            bus.rx_data  = q[i];
            bus.rx_valid = 1'b1;
            @(negedge clk);
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_result(string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, obs_wr.size(), exp_wr.size());
        foreach (exp_wr[i])
            if (i < obs_wr.size()) chk({tag, "_write"}, obs_wr[i], exp_wr[i]);
        chk({tag, "_done"}, bus.load_done, exp_done);
        chk({tag, "_err"}, bus.load_err, exp_err);
        chk({tag, "_cpu_rst"}, bus.cpu_rst, !exp_done);
        chk({tag, "_rx_ready"}, bus.rx_ready, 0);
        chk({tag, "_words"}, bus.words_loaded, exp_words);
    endtask

    task automatic run_load(byte_q_t q, int gap, string tag);
        obs_wr.delete();
        model(q);
        send(q, gap);
        check_result(tag);
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_rx_ready"}, bus.rx_ready, 1);
        chk({tag, "_cpu_rst"}, bus.cpu_rst, 1);
        chk({tag, "_done"}, bus.load_done, 0);
        chk({tag, "_err"}, bus.load_err, 0);
        chk({tag, "_words"}, bus.words_loaded, 0);
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
        check_idle("reload");
    endtask

    initial begin
        word_q_t wq;
        byte_q_t q, part;
        int n;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.reload   = 1'b0;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        check_idle("reset");
        chk("reset_mem_we", bus.mem_we, 0);
        chk("reset_mem_addr", bus.mem_addr, 0);
        chk("reset_mem_wdata", bus.mem_wdata, 0);
        mon_en = 1'b1;

        // nominal back-to-back load, checking release timing
        wq = '{32'h0842_0005, 32'h1084_0003};
        q = make_stream(2, wq, 1'b0);
        obs_wr.delete();
        model(q);
        send(q, 0);
        chk("nom_cpu_rst_next_cycle", bus.cpu_rst, 0);
        chk("nom_done_next_cycle", bus.load_done, 1);
        check_result("nom");

        // bytes offered in RUN are ignored
        obs_wr.delete();
        q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        send(q, 0);
        repeat (2) @(negedge clk);
        chk("run_ignore_writes", obs_wr.size(), 0);
        chk("run_ignore_done", bus.load_done, 1);
        chk("run_ignore_words", bus.words_loaded, 2);

        pulse_reload();
        run_load(make_stream(2, wq, 1'b1), 0, "badchk");

        // bytes offered in ERR are ignored
        obs_wr.delete();
        send(q, 0);
        repeat (2) @(negedge clk);
        chk("err_ignore_writes", obs_wr.size(), 0);
        chk("err_ignore_err", bus.load_err, 1);

        wq.delete();
        pulse_reload();
        run_load(make_stream(0, wq, 1'b0), 0, "hdr0");
        pulse_reload();
        run_load(make_stream(17, wq, 1'b0), 0, "hdr17");

        pulse_reload();
        wq = '{32'($urandom)};
        run_load(make_stream(1, wq, 1'b0), 1, "gapped");

        // reset in the middle of word 0
        pulse_reload();
        wq = '{32'hDEAD_BEEF};
        q = make_stream(1, wq, 1'b0);
        part = '{q[0], q[1], q[2]};
        obs_wr.delete();
        send(part, 0);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        check_idle("midrst");
        chk("midrst_mem_wdata", bus.mem_wdata, 0);
        chk("midrst_nwrites", obs_wr.size(), 0);
        wq = '{32'h1234_5678};
        run_load(make_stream(1, wq, 1'b0), 0, "after_rst");

        // full-depth load after reload
        pulse_reload();
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back(32'($urandom));
        run_load(make_stream(DEPTH, wq, 1'b0), 0, "full");

        // randomized loads
        for (int t = 0; t < 10; t++) begin
            pulse_reload();
            wq.delete();
            if ($urandom_range(0, 9) == 0) begin
                n = $urandom_range(DEPTH + 1, 255);
            end else begin
                n = $urandom_range(1, DEPTH);
                for (int i = 0; i < n; i++) wq.push_back(32'($urandom));
            end
            run_load(make_stream(n, wq, $urandom_range(0, 3) == 0),
                     int'($urandom_range(0, 2)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that writes the CPU's 32-bit instruction memory from a byte stream, then releases the CPU from reset. It sits between a host byte source (UART receiver or testbench) and the instruction-memory write port. It holds the CPU core in reset while loading and for the whole time after a failed load.

## Interface
- DEPTH, 16, number of instruction words in program memory (legal program length 1..DEPTH).
- AW, 4, instruction-memory address width, equal to log2(DEPTH).
- clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  reset; synchronous, active-high.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle. A transfer occurs when rx_valid and rx_ready are both high at a rising edge.
- reload  input  1  restarts a load; honoured only in RUN or ERR.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  AW  write address.
- mem_wdata  output  32  instruction word.
- cpu_rst  output  1  reset to the CPU core; high except in RUN.
- load_done  output  1  high while in RUN.
- load_err  output  1  high while in ERR.
- words_loaded  output  AW+1  number of words written in the current load.

## Operation
- Stream format, in order:
  - header byte N, the word count;
  - 4·N payload bytes, each word sent MSB first (byte 0 goes to bits 31:24);
  - one checksum byte, equal to the XOR of the header byte and all payload bytes.
- States: HDR, DATA, CHK, RUN, ERR. All outputs are registered.
- HDR
  - rx_ready = 1.
  - On a header transfer, store N and set the running XOR to the header byte.
  - If 1 ≤ N ≤ DEPTH, go to DATA with byte_idx = 0 and word_idx = 0.
  - Otherwise (N = 0 or N > DEPTH), go to ERR.
- DATA
  - rx_ready = 1.
  - Each transfer shifts the byte into a 32-bit assembly register and XORs it into the running XOR.
  - On the transfer with byte_idx = 3:
    - next cycle: mem_we = 1, mem_addr = word_idx, mem_wdata = assembled word;
    - word_idx and words_loaded increment;
    - byte_idx wraps to 0.
  - After word N−1 is written, go to CHK.
- CHK
  - rx_ready = 1.
  - On a transfer: byte equal to the running XOR → RUN; otherwise → ERR.
- RUN: rx_ready = 0, cpu_rst = 0, load_done = 1.
- ERR: rx_ready = 0, cpu_rst = 1, load_err = 1.
- reload = 1 in RUN or ERR → HDR on the next edge: cpu_rst = 1, flags cleared, words_loaded = 0. reload is ignored in HDR, DATA and CHK.
- Words already written before an error remain in memory. No rollback.
- Memory writes never go beyond address N−1.

## Timing
- Reset values: state HDR, rx_ready 1, cpu_rst 1, mem_we 0, mem_addr 0, mem_wdata 0, load_done 0, load_err 0, words_loaded 0. byte_idx, word_idx, running XOR and assembly register are all 0.
- sys_rst mid-load aborts at the next edge and restores reset values. No partial-word write is issued.
- The loader never stalls inside a load: rx_ready stays high in HDR, DATA and CHK, including the cycle mem_we is high. Back-to-back bytes every cycle are supported.
- mem_we is high for exactly one cycle, beginning the cycle after the 4th byte of a word is accepted.
- Minimum load time is 1 + 4N + 1 accepted bytes.
- The final word's mem_we cycle and the checksum acceptance may fall in the same cycle; both must complete correctly.
- cpu_rst goes low on the edge that accepts a correct checksum and registers the RUN state, i.e. visible in the following cycle.
- load_done and load_err are never high together.
- rx_valid with rx_ready low (RUN or ERR) is ignored. No state change, no XOR update.
- reload and sys_rst in the same cycle: sys_rst wins; result is identical to reload.

## Test plan
- Nominal load: N=2, words 0x0842_0005 and 0x1084_0003, checksum correct, bytes back-to-back → mem_we at addr 0 then 1 with those values. load_done=1, cpu_rst=0 one cycle after the checksum. words_loaded=2.
- Bad checksum: same stream with checksum XOR 0x01 → load_err=1, cpu_rst stays 1, both words still written, rx_ready=0.
- Bad header: N=0, then separately N=17 → ERR immediately, no mem_we, words_loaded=0.
- Gapped stream: N=1, rx_valid toggling 1/0 every cycle → same word written once. Result equals the back-to-back case.
- Reset mid-load: sys_rst after 2 payload bytes of word 0, then a full N=1 load → the first partial bytes leave no trace. Word assembled only from the new bytes. load_done=1.
- Reload: after RUN, pulse reload and load N=16 with a correct checksum → cpu_rst high throughout, addresses 0..15 written in order. words_loaded=16, load_done=1. Bytes offered while in RUN/ERR are ignored.
